mux_rr_sched: RTL and testbench
===============================

// Module: mux_rr_sched
// PURPOSE
//  Round-robin scheduler feeding the 4-lane 12-bit mux datapath: shares one output channel between four
//  requesting lanes with valid/pop handshakes. Bounded bursts per grant; words failing the lane-tag check are dropped.
//  Sits between the per-lane FIFOs (upstream, pop-driven) and the downstream consumer (valid/ready).
//  Replaces fixed priority, so lane 3 can no longer be starved.
// PARAMETERS
//  DATA_W     12  word width; bits [DATA_W-1:DATA_W-2] carry the lane tag
//  MAX_BURST  4   max words taken from one lane per grant (1..15)
//  CNT_W      8   width of saturating drop counter
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  data_in0..3 in   DATA_W  lane head words (FIFO show-ahead)
//  valid_in    in   4       bit i: lane i head word present
//  pop         out  4       bit i: lane i head consumed this cycle (combinational, one-hot or zero)
//  data_out    out  DATA_W  registered output word
//  valid_out   out  1       data_out holds a word
//  ready_in    in   1       downstream accepts data_out this cycle
//  grant_lane  out  2       lane currently/last granted (registered)
//  busy        out  1       FSM in BURST
//  drop_count  out  CNT_W   words discarded by tag check, saturating
// BEHAVIOUR
//  - Reset: data_out=0, valid_out=0, grant_lane=0, busy=0, drop_count=0, state=IDLE, rr_ptr=0; pop=0 while reset high.
//  - ld = !valid_out | ready_in. ld=0 -> full stall: pop=0, all state held.
//  - Word good iff word!=0 and word[DATA_W-1:DATA_W-2]==lane index; else dropped.
//  - Accept (pop[i]=1): ld=1 and rules below. Good word -> data_out<=word, valid_out<=1 next edge.
//    Bad word -> drop_count+1 (hold at 2^CNT_W-1), valid_out<=0. ld=1 with no accept -> valid_out<=0.
//  - Latency: accepted word visible on data_out one cycle after pop.
//  - FSM IDLE: pick first lane with valid_in set, searching rr_ptr, rr_ptr+1, ... mod 4.
//    If found and ld: pop it same cycle, grant_lane<=lane, burst_cnt<=1, ->BURST (stay IDLE if MAX_BURST==1,
//    rr_ptr<=lane+1). None valid: stay IDLE.
//  - FSM BURST (lane g=grant_lane): if ld & valid_in[g] & burst_cnt<MAX_BURST: pop g, burst_cnt++.
//    If ld & (!valid_in[g] | burst_cnt==MAX_BURST): no pop, rr_ptr<=g+1 mod 4, ->IDLE (one bubble cycle).
//    Other lanes' valid_in ignored in BURST. Dropped words count toward burst_cnt.
//  - rr_ptr wraps 3->0. Simultaneous requests resolved only by rr_ptr, never by lane number.
//  - valid_in falling mid-burst w/o pop: treated as lane empty at next ld cycle.
//  - Reset mid-burst: in-flight data_out discarded, no pop, all state back to reset values next edge.
//  - pop never asserted for a lane whose valid_in=0.
// STRUCTURE
//  - Shared pkg mux_pkg: DATA_W, TAG_W=2, LANES=4, state encoding {IDLE=0,BURST=1}, tag-field slice constants.
//  - Sub-module mux_rr_pick: combinational rotating priority encoder (req[3:0], ptr[1:0] -> found, idx[1:0]).
//  - Top: FSM + burst counter + output register + drop counter.
// TESTING
//  1 Reset: hold reset 3 cycles with all valid_in=1 -> pop=0, valid_out=0, drop_count=0 throughout.
//  2 All 4 lanes hold 6 good words each (lane i words 0x400*i+k, k=1..), ready_in=1, MAX_BURST=4 ->
//    order: lane0 x4, bubble, lane1 x4, bubble, lane2 x4, bubble, lane3 x4, then lane0 x2 (rr wrap).
//  3 Lane1 sends 0x000 then 0x801 (tag 2) then 0x405 -> drop_count=2, only 0x405 appears, from lane1.
//  4 Backpressure: ready_in low 5 cycles with valid_out=1 -> data_out stable, pop=0; resume -> no loss/dup.
//  5 Lane2 gives 2 words then valid_in[2]=0, lane0 waiting -> burst ends, lane3 checked next, lane0 served.
//  6 Assert reset mid-burst on lane3 -> next cycle state IDLE, rr_ptr=0, valid_out=0; lane0 granted first.
//  Checker: scoreboard per lane, pop onehot0, drop_count saturates at 255 after 300 bad words.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and FSM encoding for the 4-lane round-robin mux scheduler.
// Holds the default word width, the lane-tag field geometry and the state type.
package mux_pkg;
  localparam int DATA_W = 12;
  localparam int TAG_W  = 2;
  localparam int LANES  = 4;
  localparam int TAG_HI = DATA_W - 1;
  localparam int TAG_LO = DATA_W - TAG_W;
  localparam int BCNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;
endpackage

// File: rtl/mux_rr_pick.sv
// Rotating priority encoder: first set req bit searching ptr, ptr+1, ... mod 4.
// Ports: req[3:0], ptr[1:0] in; found, idx[1:0] out (idx valid when found).
module mux_rr_pick
  import mux_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [1:0]       ptr,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Walk from farthest to nearest so the lane closest to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = LANES - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one registered output among four lanes.
// Ports: clk, reset, data_in0..3, valid_in, pop, data_out, valid_out,
// ready_in, grant_lane, busy, drop_count.
module mux_rr_sched #(
  parameter int DATA_W    = mux_pkg::DATA_W,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        valid_in,
  output logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [1:0]        grant_lane,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count
);
  import mux_pkg::*;

  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

  state_e             state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         grant_q, grant_d;
  logic [BCNT_W-1:0]  burst_q, burst_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [DATA_W-1:0]  lane_data [LANES];
  logic               ld;
  logic               acc;
  logic [1:0]         sel;
  logic [DATA_W-1:0]  word;
  logic               good;
  logic               found;
  logic [1:0]         pick_idx;

  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;

  mux_rr_pick u_pick (
    .req   (valid_in),
    .ptr   (rr_ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    burst_d  = burst_q;
    data_d   = data_q;
    valid_d  = valid_q;
    drop_d   = drop_q;
    pop      = '0;
    acc      = 1'b0;
    sel      = grant_q;
    ld       = ~valid_q | ready_in;

    if (!reset && ld) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            acc     = 1'b1;
            sel     = pick_idx;
            grant_d = pick_idx;
            burst_d = BCNT_W'(1);
            if (MAX_BURST == 1) rr_ptr_d = pick_idx + 2'd1;
            else                state_d  = BURST;
          end
        end
        BURST: begin
          // Empty lane or exhausted quota closes the burst with a bubble.
          if (valid_in[grant_q] && burst_q < MAX_B) begin
            acc     = 1'b1;
            burst_d = burst_q + BCNT_W'(1);
          end else begin
            state_d  = IDLE;
            rr_ptr_d = grant_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      valid_d = 1'b0;
      if (acc) begin
        pop[sel] = 1'b1;
        if (good) begin
          data_d  = word;
          valid_d = 1'b1;
        end else if (drop_q != '1) begin
          drop_d = drop_q + CNT_W'(1);
        end
      end
    end
  end

  assign word = lane_data[sel];
  assign good = (word != '0) && (word[DATA_W-1 -: TAG_W] == sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign grant_lane = grant_q;
  assign busy       = (state_q == BURST);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: lane FIFO models, cycle reference.
// Drives directed scenarios plus randomized traffic and compares all outputs.
module tb_mux_rr_sched;
  localparam int DW = 12;
  localparam int MB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din [4];
  logic [3:0]    valid_in;
  logic [3:0]    pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic [1:0]    grant_lane;
  logic          busy;
  logic [CW-1:0] drop_count;

  always #5 clk = ~clk;

  mux_rr_sched #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in0   (din[0]),
    .data_in1   (din[1]),
    .data_in2   (din[2]),
    .data_in3   (din[3]),
    .valid_in   (valid_in),
    .pop        (pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .grant_lane (grant_lane),
    .busy       (busy),
    .drop_count (drop_count)
  );

  logic [DW-1:0] lq [4][$];
  logic [3:0]    en;
  logic          rdy;
  int            n_cmp = 0;
  int            n_err = 0;

  // reference state
  bit            m_vout;
  logic [DW-1:0] m_dout;
  int            m_grant, m_taken, m_ptr, m_drop;
  bit            m_busy;

  logic [DW-1:0] got[$];
  int            plog[$];

  task automatic model_reset();
    m_vout = 0; m_dout = '0; m_grant = 0; m_taken = 0;
    m_ptr = 0; m_drop = 0; m_busy = 0;
  endtask

  function automatic bit is_good(logic [DW-1:0] w, int lane);
    return (w != 0) && ((int'(w) / 1024) == lane);
  endfunction

  task automatic cyc();
    logic [3:0]    vin;
    logic [3:0]    ep;
    logic [DW-1:0] w;
    int            l;
    bit            take;
    for (int i = 0; i < 4; i++) begin
      vin[i] = en[i] && (lq[i].size() > 0);
      din[i] = (lq[i].size() > 0) ? lq[i][0] : '0;
    end
    valid_in = vin;
    ready_in = rdy;
    #2;
    ep = '0; take = 0; l = 0; w = '0;
    if (!reset && (!m_vout || rdy)) begin
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!take && vin[(m_ptr + k) % 4]) begin
            take = 1; l = (m_ptr + k) % 4;
          end
        end
        if (take) begin
          m_grant = l; m_taken = 1;
          if (MB > 1) m_busy = 1;
          else        m_ptr = (l + 1) % 4;
        end
      end else begin
        if (vin[m_grant] && m_taken < MB) begin
          take = 1; l = m_grant; m_taken++;
        end else begin
          m_busy = 0; m_ptr = (m_grant + 1) % 4;
        end
      end
      m_vout = 0;
      if (take) begin
        ep[l] = 1'b1;
        w = lq[l][0];
        if (is_good(w, l)) begin
          m_dout = w; m_vout = 1;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    n_cmp++;
    if (pop !== ep) begin
      n_err++; $display("FAIL pop: got %b want %b", pop, ep);
    end
    n_cmp++;
    if (!$onehot0(pop) || (pop & ~vin) != 0) begin
      n_err++; $display("FAIL pop_legal: pop %b valid_in %b", pop, vin);
    end
    if (!reset && valid_out && ready_in) got.push_back(data_out);
    for (int i = 0; i < 4; i++)
      if (ep[i]) begin
        plog.push_back(i);
        void'(lq[i].pop_front());
      end
    if (reset) model_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (valid_out !== m_vout) begin
      n_err++; $display("FAIL valid_out: got %b want %b", valid_out, m_vout);
    end
    if (m_vout) begin
      n_cmp++;
      if (data_out !== m_dout) begin
        n_err++; $display("FAIL data_out: got %h want %h", data_out, m_dout);
      end
    end
    n_cmp++;
    if (grant_lane !== 2'(m_grant)) begin
      n_err++; $display("FAIL grant_lane: got %0d want %0d", grant_lane, m_grant);
    end
    n_cmp++;
    if (busy !== m_busy) begin
      n_err++; $display("FAIL busy: got %b want %b", busy, m_busy);
    end
    n_cmp++;
    if (drop_count !== CW'(m_drop)) begin
      n_err++; $display("FAIL drop_count: got %0d want %0d", drop_count, m_drop);
    end
  endtask

  function automatic bit idle_now();
    bit r = !m_vout && !m_busy;
    for (int i = 0; i < 4; i++)
      if (en[i] && lq[i].size() > 0) r = 0;
    return r;
  endfunction

  task automatic run_idle(int bound);
    int n = 0;
    while (!idle_now()) begin
      cyc();
      n++;
      if (n > bound) begin
        n_cmp++; n_err++;
        $display("FAIL run_idle: timeout after %0d cycles, want idle", n);
        break;
      end
    end
    cyc();
  endtask

  task automatic apply_reset();
    reset = 1; cyc(); cyc(); reset = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      lq[i].push_back(DW'(1024 * i + 1));
      lq[i].push_back(DW'(1024 * i + 2));
    end
    en = 4'hF; rdy = 1; reset = 1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_cmp++;
      if (valid_out !== 1'b0 || drop_count !== '0 || data_out !== '0) begin
        n_err++;
        $display("FAIL reset_state: vout %b drop %0d dout %h want 0 0 0",
                 valid_out, drop_count, data_out);
      end
    end
    for (int i = 0; i < 4; i++) lq[i].delete();
    reset = 0;
  endtask

  task automatic test_rr_order();
    logic [DW-1:0] exp[$];
    got.delete(); plog.delete();
    for (int i = 0; i < 4; i++)
      for (int k = 1; k <= 6; k++) lq[i].push_back(DW'(1024 * i + k));
    for (int i = 0; i < 4; i++)
      for (int k = 1; k <= 4; k++) exp.push_back(DW'(1024 * i + k));
    for (int i = 0; i < 4; i++)
      for (int k = 5; k <= 6; k++) exp.push_back(DW'(1024 * i + k));
    en = 4'hF; rdy = 1;
    run_idle(200);
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_err++; $display("FAIL rr_count: got %0d want %0d", got.size(), exp.size());
    end
    for (int j = 0; j < exp.size() && j < got.size(); j++) begin
      n_cmp++;
      if (got[j] !== exp[j]) begin
        n_err++; $display("FAIL rr_order[%0d]: got %h want %h", j, got[j], exp[j]);
      end
    end
  endtask

  task automatic test_tag_drop();
    int d0 = m_drop;
    got.delete(); plog.delete();
    lq[1].push_back(12'h000);
    lq[1].push_back(12'h801);
    lq[1].push_back(12'h405);
    run_idle(50);
    n_cmp++;
    if (drop_count !== CW'(d0 + 2)) begin
      n_err++; $display("FAIL tag_drop_cnt: got %0d want %0d", drop_count, d0 + 2);
    end
    n_cmp++;
    if (got.size() != 1 || got[0] !== 12'h405) begin
      n_err++; $display("FAIL tag_drop_out: got %0d words want 1 (0x405)", got.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e0[$], e2[$], g0[$], g2[$];
    logic [DW-1:0] hold;
    got.delete();
    for (int k = 0; k < 5; k++) begin
      e0.push_back(DW'(1 + $urandom_range(0, 1022)));
      e2.push_back(DW'(2048 + $urandom_range(0, 1023)));
    end
    foreach (e0[k]) lq[0].push_back(e0[k]);
    foreach (e2[k]) lq[2].push_back(e2[k]);
    rdy = 1;
    cyc(); cyc(); cyc();
    hold = data_out;
    rdy = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_cmp++;
      if (data_out !== hold || pop !== 4'b0) begin
        n_err++;
        $display("FAIL stall: dout %h want %h pop %b want 0", data_out, hold, pop);
      end
    end
    rdy = 1;
    run_idle(100);
    foreach (got[k]) begin
      if (got[k][11:10] == 2'd0) g0.push_back(got[k]);
      else                       g2.push_back(got[k]);
    end
    n_cmp++;
    if (g0 != e0 || g2 != e2) begin
      n_err++;
      $display("FAIL bp_scoreboard: got %0d/%0d words want %0d/%0d in order",
               g0.size(), g2.size(), e0.size(), e2.size());
    end
  endtask

  task automatic test_lane_empty();
    int n = 0;
    apply_reset();
    lq[1].push_back(12'h401);
    run_idle(20);
    plog.delete();
    for (int k = 1; k <= 4; k++) lq[2].push_back(DW'(2048 + k));
    lq[0].push_back(12'h011);
    lq[0].push_back(12'h012);
    while (plog.size() < 2 && n < 20) begin cyc(); n++; end
    en[2] = 0;
    run_idle(30);
    n_cmp++;
    if (plog.size() != 4 || plog[0] != 2 || plog[1] != 2 ||
        plog[2] != 0 || plog[3] != 0) begin
      n_err++;
      $display("FAIL lane_empty_order: got %0d pops (first %0d) want 2,2,0,0",
               plog.size(), plog.size() > 0 ? plog[0] : -1);
    end
    en[2] = 1;
    run_idle(30);
    n_cmp++;
    if (plog.size() != 6 || plog[4] != 2 || plog[5] != 2) begin
      n_err++; $display("FAIL lane_resume: got %0d pops want 6", plog.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    lq[2].push_back(12'h801);
    run_idle(20);
    plog.delete();
    for (int k = 1; k <= 6; k++) lq[3].push_back(DW'(3072 + k));
    while (plog.size() < 2 && n < 20) begin cyc(); n++; end
    reset = 1; cyc(); reset = 0;
    n_cmp++;
    if (busy !== 1'b0 || valid_out !== 1'b0 || grant_lane !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid: busy %b vout %b grant %0d want 0 0 0",
               busy, valid_out, grant_lane);
    end
    plog.delete();
    lq[0].push_back(12'h021);
    lq[0].push_back(12'h022);
    run_idle(60);
    n_cmp++;
    if (plog.size() == 0 || plog[0] != 0) begin
      n_err++;
      $display("FAIL reset_mid_first: got lane %0d want 0",
               plog.size() > 0 ? plog[0] : -1);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (lq[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          w = DW'(1024 * i + $urandom_range(1, 1023));
          if ($urandom_range(0, 7) == 0) w = DW'($urandom_range(0, 4095));
          lq[i].push_back(w);
        end
      end
      en  = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    en = 4'hF; rdy = 1;
    run_idle(300);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) begin
      if (k % 3 == 0) lq[0].push_back(12'h000);
      else            lq[0].push_back(DW'(1024 * $urandom_range(1, 3) + k % 1000 + 1));
    end
    run_idle(3000);
    n_cmp++;
    if (drop_count !== 8'd255) begin
      n_err++; $display("FAIL drop_saturate: got %0d want 255", drop_count);
    end
  endtask

  initial begin
    reset = 1; rdy = 1; en = 4'hF; valid_in = '0; ready_in = 1;
    for (int i = 0; i < 4; i++) din[i] = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_rr_order();
    test_tag_drop();
    test_backpressure();
    test_lane_empty();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
